// File: rtl/x_host.sv
// rtl/x_host.sv - word-level request initiator for the delay-line byte protocol
// Emits nibble-coded command bytes and gathers returned bytes over valid/accept.
module x_host #(
  parameter int CAP_WAIT = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [31:0] i_cmd_data,
  output logic        o_rsp_valid,
  output logic        o_rsp_err,
  output logic [31:0] o_rsp_data,
  output logic        o_valid,
  output logic [7:0]  o_data,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_accept
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAP,
    S_UNL,
    S_WAIT,
    S_RSP
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_CAP   = 2'd2;
  localparam logic [7:0] CMD_UNL  = 8'h01;
  localparam logic [7:0] CMD_CAP  = 8'h02;
  localparam logic [7:0] CAP_LAST = 8'(CAP_WAIT);
  localparam logic [3:0] TO_LAST  = 4'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [3:0]  wcnt, wcnt_d;
  logic [1:0]  bcnt, bcnt_d;
  logic [31:0] shreg, shreg_d;
  logic        valid_d;
  logic [7:0]  data_d;
  logic        rsp_valid_d;
  logic        rsp_err_d;
  logic [31:0] rsp_data_d;
  logic        ready_d;

  // Returned bytes are only consumed while waiting for one; otherwise they stay pending.
  assign o_accept = (state == S_WAIT) & i_valid;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    wcnt_d      = wcnt;
    bcnt_d      = bcnt;
    shreg_d     = shreg;
    valid_d     = 1'b0;
    data_d      = o_data;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = o_rsp_data;
    case (state)
      S_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          case (i_cmd_op)
            OP_LOAD: begin
              state_d = S_LOAD;
              valid_d = 1'b1;
              data_d  = {i_cmd_data[31:28], 4'h0};
              shreg_d = {i_cmd_data[27:0], 4'h0};
              cnt_d   = 8'd1;
            end
            OP_READ: begin
              state_d = S_UNL;
              valid_d = 1'b1;
              data_d  = CMD_UNL;
              bcnt_d  = 2'd0;
            end
            OP_CAP: begin
              state_d = S_CAP;
              valid_d = 1'b1;
              data_d  = CMD_CAP;
              cnt_d   = 8'd0;
            end
            default: begin
              state_d     = S_RSP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (cnt == 8'd8) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          data_d  = {shreg[31:28], 4'h0};
          shreg_d = {shreg[27:0], 4'h0};
          cnt_d   = cnt + 8'd1;
        end
      end
      S_CAP: begin
        if (cnt == CAP_LAST) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_UNL: begin
        state_d = S_WAIT;
        wcnt_d  = 4'd0;
      end
      S_WAIT: begin
        if (i_valid) begin
          shreg_d = {shreg[23:0], i_data};
          bcnt_d  = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {shreg[23:0], i_data};
          end else begin
            state_d = S_UNL;
            valid_d = 1'b1;
            data_d  = CMD_UNL;
          end
        end else if (wcnt == TO_LAST) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 32'h0;
        end else begin
          wcnt_d = wcnt + 4'd1;
        end
      end
      S_RSP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Outputs are registered from the next-state decision so they line up with the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      wcnt        <= 4'd0;
      bcnt        <= 2'd0;
      shreg       <= 32'h0;
      o_valid     <= 1'b0;
      o_data      <= 8'h0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_data  <= 32'h0;
      o_cmd_ready <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      wcnt        <= wcnt_d;
      bcnt        <= bcnt_d;
      shreg       <= shreg_d;
      o_valid     <= valid_d;
      o_data      <= data_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_err   <= rsp_err_d;
      o_rsp_data  <= rsp_data_d;
      o_cmd_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_x_host.sv
// tb/tb_x_host.sv - randomized self-checking bench for x_host
// Expected link traffic is planned per request from protocol timing rules.
module tb_x_host;
  localparam int CAP_WAIT = 4;
  localparam int TIMEOUT  = 15;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op = 2'd0;
  logic [31:0] i_cmd_data = 32'h0;
  logic        o_rsp_valid;
  logic        o_rsp_err;
  logic [31:0] o_rsp_data;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h0;
  logic        o_accept;

  always #5 i_clk = ~i_clk;

  x_host #(.CAP_WAIT(CAP_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rsp_data(o_rsp_data),
    .o_valid(o_valid), .o_data(o_data),
    .i_valid(i_valid), .i_data(i_data), .o_accept(o_accept)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_rsp_data;
  int          lat[4];
  int          hold_k;
  logic        e_val[64];
  logic [7:0]  e_byte[64];
  logic        e_acc[64];
  logic        d_val[64];
  logic [7:0]  d_dat[64];
  logic        in_wait[64];
  int          rsp_n;
  logic        e_err;
  logic [31:0] e_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bits"}, {27'h0, o_valid, o_rsp_valid, o_rsp_err, o_cmd_ready, o_accept}, 32'h0);
    chk({tag, "_odata"}, {24'h0, o_data}, 32'h0);
    chk({tag, "_rdata"}, o_rsp_data, 32'h0);
  endtask

  // Build the expected cycle-by-cycle picture (index 1 = first cycle after acceptance).
  task automatic plan(input logic [1:0] op, input logic [31:0] word);
    int u;
    int c;
    logic [31:0] acc;
    logic [7:0] b;
    logic done;
    for (int i = 0; i < 64; i++) begin
      e_val[i] = 1'b0; e_byte[i] = 8'h0; e_acc[i] = 1'b0;
      d_val[i] = 1'b0; d_dat[i] = 8'($urandom); in_wait[i] = 1'b0;
    end
    e_err = 1'b0;
    e_rdata = m_rsp_data;
    case (op)
      2'd0: begin
        for (int k = 0; k < 8; k++) begin
          e_val[1 + k] = 1'b1;
          e_byte[1 + k] = {word[31 - 4 * k -: 4], 4'h0};
        end
        rsp_n = 9;
      end
      2'd2: begin
        e_val[1] = 1'b1;
        e_byte[1] = 8'h02;
        rsp_n = 2 + CAP_WAIT;
      end
      2'd1: begin
        u = 1; acc = 32'h0; done = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!done) begin
            e_val[u] = 1'b1;
            e_byte[u] = 8'h01;
            if (k == hold_k) begin
              for (int w = u + 1; w <= u + TIMEOUT; w++) in_wait[w] = 1'b1;
              rsp_n = u + 1 + TIMEOUT;
              e_err = 1'b1;
              e_rdata = 32'h0;
              done = 1'b1;
            end else begin
              c = u + 1 + lat[k];
              for (int w = u + 1; w <= c; w++) in_wait[w] = 1'b1;
              b = 8'($urandom);
              d_val[c] = 1'b1; d_dat[c] = b; e_acc[c] = 1'b1;
              acc = {acc[23:0], b};
              u = c + 1;
            end
          end
        end
        if (!done) begin
          rsp_n = u;
          e_rdata = acc;
        end
      end
      default: begin
        rsp_n = 1;
        e_err = 1'b1;
      end
    endcase
    // Stray returned bytes while the host is not waiting must be left alone.
    for (int n = 1; n <= rsp_n; n++)
      if (!in_wait[n] && !d_val[n] && $urandom_range(0, 3) == 0) d_val[n] = 1'b1;
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge i_clk);
    while (!o_cmd_ready && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    chk("ready_wait", o_cmd_ready, 1'b1);
  endtask

  task automatic run_req(input logic [1:0] op, input logic [31:0] word);
    plan(op, word);
    wait_ready();
    i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_data = word;
    i_valid = 1'($urandom_range(0, 1)); i_data = 8'($urandom);
    #1 chk("accept_idle", o_accept, 1'b0);
    for (int n = 1; n <= rsp_n + 1; n++) begin
      @(negedge i_clk);
      i_cmd_valid = (n <= rsp_n) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_cmd_op = 2'($urandom);
      i_cmd_data = $urandom;
      i_valid = d_val[n]; i_data = d_dat[n];
      #1;
      chk("cmd_ready", o_cmd_ready, n == rsp_n + 1);
      chk("o_valid", o_valid, e_val[n]);
      if (e_val[n]) chk("o_data", o_data, e_byte[n]);
      chk("o_accept", o_accept, e_acc[n]);
      chk("rsp_valid", o_rsp_valid, n == rsp_n);
      chk("rsp_err", o_rsp_err, (n == rsp_n) && e_err);
      chk("rsp_data", o_rsp_data, (n >= rsp_n) ? e_rdata : m_rsp_data);
    end
    i_valid = 1'b0;
    i_cmd_valid = 1'b0;
    m_rsp_data = e_rdata;
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3, input int h);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3; hold_k = h;
  endtask

  initial begin
    m_rsp_data = 32'h0;
    set_lat(0, 0, 0, 0, 4);
    #2 chk_all_zero("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("ready_after_reset", o_cmd_ready, 1'b1);

    run_req(2'd0, 32'h1234_ABCD);
    run_req(2'd2, 32'h0);
    run_req(2'd1, 32'h0);
    set_lat(0, 0, 0, 0, 2);
    run_req(2'd1, 32'h0);
    set_lat(0, 1, 2, 3, 4);
    run_req(2'd1, 32'h0);
    run_req(2'd3, 32'h0);

    // Reset while the fourth LOAD byte is on the link.
    plan(2'd0, 32'hCAFE_F00D);
    wait_ready();
    i_cmd_valid = 1'b1; i_cmd_op = 2'd0; i_cmd_data = 32'hCAFE_F00D;
    for (int n = 1; n <= 4; n++) begin
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      #1 chk("rst_seq_byte", o_data, e_byte[n]);
    end
    i_rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge i_clk);
    chk("no_rsp_in_reset", o_rsp_valid, 1'b0);
    i_rst_n = 1'b1;
    m_rsp_data = 32'h0;
    @(negedge i_clk);
    chk("ready_after_rst2", o_cmd_ready, 1'b1);
    run_req(2'd0, 32'h8765_4321);

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 4; k++) lat[k] = $urandom_range(0, 3);
      hold_k = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 4;
      run_req(2'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/x_host.md
Name: x_host

Overview:
- Command initiator for the delay-line byte protocol. It is the opposite end of the link from the on-chip delay-line driver.
- Converts word-level requests (LOAD a 32-bit word, trigger CAPTURE, READ the 32-bit capture) into the driver's byte command stream: low nibble is the opcode, high nibble is the payload.
- Collects returned bytes through the driver's valid/accept handshake.
- Sits between the on-chip self-test/control logic and the driver, in place of the UART receive/transmit path.

Parameters:
CAP_WAIT, 4, cycles waited after the capture command is sent before completion; must be >= 3 to cover the driver's 3-stage capture pipe.
TIMEOUT, 15, maximum cycles spent waiting for a returned byte before aborting a READ; 4-bit counter.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  request valid
o_cmd_ready  out  1  high only in IDLE
i_cmd_op  in  2  0=LOAD, 1=READ, 2=CAPTURE, 3=illegal
i_cmd_data  in  32  LOAD word; sampled on acceptance
o_rsp_valid  out  1  one-cycle completion pulse
o_rsp_err  out  1  qualifies o_rsp_valid: timeout or illegal op
o_rsp_data  out  32  READ result; holds until the next READ completes
o_valid  out  1  command byte valid to driver (no backpressure)
o_data  out  8  command byte
i_valid  in  1  returned byte valid from driver
i_data  in  8  returned byte
o_accept  out  1  returned byte consumed

Behaviour:
- Reset (async, i_rst_n low):
  - State IDLE, counters cleared.
  - All outputs 0, except o_cmd_ready, which is 1 once reset is released.
  - Reset mid-operation aborts with no response; the partial byte stream is not completed.
- Acceptance: on cycle T with i_cmd_valid & o_cmd_ready, op and data are registered. o_cmd_ready drops at T+1.
- States: IDLE, LOAD, CAP, UNL, WAIT, RSP.
- LOAD:
  - o_valid=1 on T+1..T+8, i.e. 8 consecutive bytes.
  - Byte k (k=0..7) = {word[31-4k:28-4k], 4'h0}, most significant nibble first.
  - RSP at T+9: o_rsp_valid=1, o_rsp_err=0.
- CAPTURE:
  - o_valid=1 with o_data=8'h02 on T+1.
  - CAP state counts CAP_WAIT cycles with o_valid=0.
  - RSP at T+2+CAP_WAIT, err=0. The default gives T+6.
- READ:
  - For each of 4 bytes: UNL drives o_valid=1, o_data=8'h01 for one cycle, then WAIT.
  - In WAIT, o_accept = i_valid, combinationally, only while in WAIT.
  - When i_valid is seen, i_data shifts into the low byte of the shift register (first byte ends up in [31:24]); next state is UNL for the next byte, or RSP after the 4th byte.
  - With a zero-latency driver (valid one cycle after unload), bytes are captured at T+2, T+4, T+6, T+8 and RSP is at T+9.
  - On RSP, o_rsp_data is loaded with {b0,b1,b2,b3}.
- Timeout:
  - WAIT counter clears on entry to WAIT.
  - If TIMEOUT cycles elapse with no i_valid: go to RSP with err=1, o_rsp_data cleared to 0, remaining bytes abandoned.
- Illegal op 3: no link activity; RSP at T+1 with err=1; o_rsp_data unchanged.
- RSP lasts one cycle (o_rsp_valid pulse), then IDLE; o_cmd_ready=1 on the following cycle.
- i_valid outside WAIT is ignored: o_accept stays 0 and the byte stays pending at the driver.
- o_valid is never high on two different command types in one cycle; at most one byte per cycle.
- o_rsp_err is 0 whenever o_rsp_valid is 0.
- All outputs except o_accept are registered.

Test Plan:
- LOAD 32'h1234_ABCD accepted at T -> o_data sequence 10,20,30,40,A0,B0,C0,D0 on T+1..T+8; o_rsp_valid, err=0 at T+9; o_cmd_ready high at T+10.
- CAPTURE at T -> single 8'h02 at T+1, no o_valid through T+5, rsp at T+6. Against the real driver with i_dl=32'hDEAD_BEEF, a following READ returns o_rsp_data=32'hDEAD_BEEF.
- READ with driver model returning 8'h11,22,33,44 with 0 extra latency -> four 8'h01 bytes at T+1,3,5,7; o_accept pulses at T+2,4,6,8; rsp at T+9, o_rsp_data=32'h1122_3344, err=0.
- READ where the model withholds the 3rd byte -> after 15 cycles in WAIT: rsp with err=1, o_rsp_data=0; next request accepted normally.
- Op 3 at T -> no o_valid; rsp at T+1 with err=1; previous o_rsp_data retained. A stray i_valid in IDLE gives o_accept=0.
- i_rst_n low during byte 4 of LOAD -> all outputs 0 immediately, no rsp; after release, o_cmd_ready=1 and a new LOAD completes correctly.
